// File: rtl/micro_seq_pkg.sv
// Shared encodings for the picoRISC microprogram sequencer: branch types,
// fault causes and FSM states.
package micro_seq_pkg;

    typedef enum logic [2:0] {
        BR_SEQ  = 3'd0,
        BR_JMP  = 3'd1,
        BR_BRC  = 3'd2,
        BR_BRNC = 3'd3,
        BR_DISP = 3'd4,
        BR_CALL = 3'd5,
        BR_RET  = 3'd6,
        BR_WAIT = 3'd7
    } br_t;

    typedef enum logic [1:0] {
        FC_NONE      = 2'b00,
        FC_OVERFLOW  = 2'b01,
        FC_UNDERFLOW = 2'b10,
        FC_DISP_MISS = 2'b11
    } fault_cause_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAITING = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bundle between the microinstruction/decoder side and the sequencer.
interface micro_sequencer_if #(
    parameter int AW = 8,
    parameter int NC = 16,
    parameter int SD = 4
);
    logic [2:0]            br_type;
    logic [AW-1:0]         br_target;
    logic [$clog2(NC)-1:0] cond_sel;
    logic [NC-1:0]         cond;
    logic [AW-1:0]         disp_addr;
    logic                  disp_valid;
    logic                  stall;
    logic [AW-1:0]         mpc;
    logic                  waiting;
    logic                  fault;
    logic [1:0]            fault_cause;
    logic [$clog2(SD):0]   sp;

    modport master (
        output br_type, br_target, cond_sel, cond, disp_addr, disp_valid, stall,
        input  mpc, waiting, fault, fault_cause, sp
    );

    modport slave (
        input  br_type, br_target, cond_sel, cond, disp_addr, disp_valid, stall,
        output mpc, waiting, fault, fault_cause, sp
    );
endinterface

// File: rtl/micro_ret_stack.sv
// SD-deep LIFO of micro return addresses. Push/pop are assumed pre-gated by
// the sequencer; overflow/underflow requests are simply ignored here.
module micro_ret_stack #(
    parameter int AW = 8,
    parameter int SD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic [AW-1:0]       push_data,
    output logic [AW-1:0]       top,
    output logic                full,
    output logic                empty,
    output logic [$clog2(SD):0] sp
);
    localparam int SPW = $clog2(SD) + 1;
    localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

    logic [AW-1:0]  mem [SD];
    logic [SPW-1:0] cnt;

    assign full  = (cnt == SPW'(SD));
    assign empty = (cnt == '0);
    assign sp    = cnt;
    assign top   = mem[IW'(cnt - SPW'(1))];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + SPW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - SPW'(1);
        end
    end

    // Storage is not reset; only the occupancy count defines validity.
    always_ff @(posedge clk) begin
        if (rst_n && push && !full) begin
            mem[IW'(cnt)] <= push_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-program counter and next-address logic for the picoRISC control unit.
// The control ROM is read asynchronously at mpc; the next mpc is registered.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int            AW         = 8,
    parameter int            NC         = 16,
    parameter int            SD         = 4,
    parameter logic [AW-1:0] FAULT_ADDR = AW'(255)
) (
    input  logic               clk,
    input  logic               rst_n,
    micro_sequencer_if.slave   bus
);
    localparam int CW = $clog2(NC);

    state_t       state_q, state_n;
    fault_cause_t cause_q, cause_n;
    logic [AW-1:0] mpc_q, mpc_n, mpc_inc;
    logic [CW-1:0] wsel_q, wsel_n;

    logic          push, pop, push_en, pop_en;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    assign mpc_inc = mpc_q + AW'(1);
    assign push_en = push && !bus.stall;
    assign pop_en  = pop && !bus.stall;

    micro_ret_stack #(.AW(AW), .SD(SD)) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_en),
        .pop       (pop_en),
        .push_data (mpc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .sp        (bus.sp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cause_q <= FC_NONE;
            mpc_q   <= '0;
            wsel_q  <= '0;
        end else if (!bus.stall) begin
            state_q <= state_n;
            cause_q <= cause_n;
            mpc_q   <= mpc_n;
            wsel_q  <= wsel_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        mpc_n   = mpc_q;
        wsel_n  = wsel_q;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                unique case (br_t'(bus.br_type))
                    BR_SEQ:  mpc_n = mpc_inc;
                    BR_JMP:  mpc_n = bus.br_target;
                    BR_BRC:  mpc_n = bus.cond[bus.cond_sel] ? bus.br_target : mpc_inc;
                    BR_BRNC: mpc_n = bus.cond[bus.cond_sel] ? mpc_inc : bus.br_target;
                    BR_DISP: begin
                        if (bus.disp_valid) begin
                            mpc_n = bus.disp_addr;
                        end else begin
                            state_n = ST_FAULT;
                            cause_n = FC_DISP_MISS;
                            mpc_n   = FAULT_ADDR;
                        end
                    end
                    BR_CALL: begin
                        if (stk_full) begin
                            state_n = ST_FAULT;
                            cause_n = FC_OVERFLOW;
                            mpc_n   = FAULT_ADDR;
                        end else begin
                            push  = 1'b1;
                            mpc_n = bus.br_target;
                        end
                    end
                    BR_RET: begin
                        if (stk_empty) begin
                            state_n = ST_FAULT;
                            cause_n = FC_UNDERFLOW;
                            mpc_n   = FAULT_ADDR;
                        end else begin
                            pop   = 1'b1;
                            mpc_n = stk_top;
                        end
                    end
                    BR_WAIT: begin
                        if (bus.cond[bus.cond_sel]) begin
                            mpc_n = mpc_inc;
                        end else begin
                            state_n = ST_WAITING;
                            wsel_n  = bus.cond_sel;
                        end
                    end
                    default: mpc_n = mpc_inc;
                endcase
            end
            ST_WAITING: begin
                // Only the select latched on entry matters; live fields are ignored.
                if (bus.cond[wsel_q]) begin
                    mpc_n   = mpc_inc;
                    state_n = ST_RUN;
                end
            end
            ST_FAULT: mpc_n = FAULT_ADDR;
            default: begin
                state_n = ST_FAULT;
                mpc_n   = FAULT_ADDR;
            end
        endcase
    end

    assign bus.mpc         = mpc_q;
    assign bus.waiting     = (state_q == ST_WAITING);
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.fault_cause = cause_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer, plus a hand-written
// nested CALL/RET and long-WAIT sequence.
module tb_micro_sequencer;
    import micro_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    micro_sequencer_if #(.AW(8), .NC(16), .SD(4)) bus ();

    micro_sequencer #(.AW(8), .NC(16), .SD(4), .FAULT_ADDR(8'd255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [2:0]  br;
        logic [7:0]  tgt;
        logic [3:0]  sel;
        logic [15:0] cond;
        logic [7:0]  disp;
        logic        dv;
        logic [7:0]  e_mpc;
        logic        e_w;
        logic        e_f;
        logic [1:0]  e_c;
        logic [2:0]  e_sp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic st, logic [2:0] br, logic [7:0] tgt,
                                logic [3:0] sel, logic [15:0] cnd, logic [7:0] dsp,
                                logic dv, logic [7:0] em, logic ew, logic ef,
                                logic [1:0] ec, logic [2:0] esp);
        vec_t v;
        v.rst_n = r;  v.stall = st; v.br = br; v.tgt = tgt; v.sel = sel;
        v.cond = cnd; v.disp = dsp; v.dv = dv;
        v.e_mpc = em; v.e_w = ew; v.e_f = ef; v.e_c = ec; v.e_sp = esp;
        vecs.push_back(v);
    endfunction

    task automatic drive(logic r, logic st, logic [2:0] br, logic [7:0] tgt,
                         logic [3:0] sel, logic [15:0] cnd, logic [7:0] dsp, logic dv);
        @(negedge clk);
        rst_n          = r;
        bus.stall      = st;
        bus.br_type    = br;
        bus.br_target  = tgt;
        bus.cond_sel   = sel;
        bus.cond       = cnd;
        bus.disp_addr  = dsp;
        bus.disp_valid = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int got, int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.stall = 1'b0; bus.br_type = '0; bus.br_target = '0; bus.cond_sel = '0;
        bus.cond = '0; bus.disp_addr = '0; bus.disp_valid = 1'b0;

        //   rst st  br       tgt  sel cond      disp dv  mpc w  f  c  sp
        add(0, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0); // 0 reset
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  1,  0, 0, 0, 0);
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  2,  0, 0, 0, 0);
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  3,  0, 0, 0, 0);
        add(1, 0, BR_BRC,  40,  2, 16'h0004, 0,  0,  40, 0, 0, 0, 0); // 4
        add(1, 0, BR_BRC,  60,  2, 16'h0000, 0,  0,  41, 0, 0, 0, 0);
        add(1, 0, BR_BRNC, 50,  2, 16'h0000, 0,  0,  50, 0, 0, 0, 0);
        add(1, 0, BR_BRNC, 70,  2, 16'h0004, 0,  0,  51, 0, 0, 0, 0);
        add(1, 0, BR_JMP,  10,  0, 16'h0000, 0,  0,  10, 0, 0, 0, 0); // 8
        add(1, 0, BR_CALL, 43,  0, 16'h0000, 0,  0,  43, 0, 0, 0, 1);
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0,  11, 0, 0, 0, 0);
        add(1, 0, BR_CALL, 100, 0, 16'h0000, 0,  0, 100, 0, 0, 0, 1);
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0,  12, 0, 0, 0, 0); // 12
        add(1, 0, BR_DISP, 0,   0, 16'h0000, 25, 1,  25, 0, 0, 0, 0);
        add(1, 0, BR_BRC,  77,  2, 16'h0008, 0,  0,  26, 0, 0, 0, 0);
        add(1, 0, BR_JMP,  22,  0, 16'h0000, 0,  0,  22, 0, 0, 0, 0);
        add(1, 0, BR_WAIT, 0,   0, 16'h0000, 0,  0,  22, 1, 0, 0, 0); // 16
        add(1, 0, BR_JMP,  99,  5, 16'h0020, 0,  0,  22, 1, 0, 0, 0);
        add(1, 0, BR_JMP,  99,  5, 16'h0020, 0,  0,  22, 1, 0, 0, 0);
        add(1, 0, BR_JMP,  99,  5, 16'h0001, 0,  0,  23, 0, 0, 0, 0);
        add(1, 0, BR_WAIT, 0,   1, 16'h0002, 0,  0,  24, 0, 0, 0, 0); // 20
        add(1, 0, BR_JMP,  255, 0, 16'h0000, 0,  0, 255, 0, 0, 0, 0);
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_JMP,  255, 0, 16'h0000, 0,  0, 255, 0, 0, 0, 0);
        add(1, 0, BR_CALL, 7,   0, 16'h0000, 0,  0,  7,  0, 0, 0, 1); // 24
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 1, BR_CALL, 30,  0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 1, BR_CALL, 30,  0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_CALL, 30,  0, 16'h0000, 0,  0,  30, 0, 0, 0, 1); // 28
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0,  1,  0, 0, 0, 0);
        add(1, 1, BR_JMP,  5,   0, 16'h0000, 0,  0,  1,  0, 0, 0, 0);
        add(1, 0, BR_WAIT, 0,   0, 16'h0000, 0,  0,  1,  1, 0, 0, 0);
        add(1, 1, BR_SEQ,  0,   0, 16'h0001, 0,  0,  1,  1, 0, 0, 0); // 32
        add(1, 0, BR_SEQ,  0,   0, 16'h0001, 0,  0,  2,  0, 0, 0, 0);
        add(1, 0, BR_DISP, 0,   0, 16'h0000, 9,  0, 255, 0, 1, 3, 0);
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0, 255, 0, 1, 3, 0);
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0, 255, 0, 1, 3, 0); // 36
        add(0, 1, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_RET,  0,   0, 16'h0000, 0,  0, 255, 0, 1, 2, 0);
        add(0, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_CALL, 1,   0, 16'h0000, 0,  0,  1,  0, 0, 0, 1); // 40
        add(1, 0, BR_CALL, 2,   0, 16'h0000, 0,  0,  2,  0, 0, 0, 2);
        add(1, 0, BR_CALL, 3,   0, 16'h0000, 0,  0,  3,  0, 0, 0, 3);
        add(1, 0, BR_CALL, 4,   0, 16'h0000, 0,  0,  4,  0, 0, 0, 4);
        add(1, 0, BR_CALL, 5,   0, 16'h0000, 0,  0, 255, 0, 1, 1, 4); // 44
        add(0, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_WAIT, 0,   0, 16'h0000, 0,  0,  0,  1, 0, 0, 0);
        add(0, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  0,  0, 0, 0, 0);
        add(1, 0, BR_SEQ,  0,   0, 16'h0000, 0,  0,  1,  0, 0, 0, 0); // 48

        for (int i = 0; i < vecs.size(); i++) begin
            logic [14:0] got, exp;
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt,
                  vecs[i].sel, vecs[i].cond, vecs[i].disp, vecs[i].dv);
            got = {bus.mpc, bus.waiting, bus.fault, bus.fault_cause, bus.sp};
            exp = {vecs[i].e_mpc, vecs[i].e_w, vecs[i].e_f, vecs[i].e_c, vecs[i].e_sp};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL vec%0d: got mpc=%0d w=%0b f=%0b c=%0d sp=%0d, expected mpc=%0d w=%0b f=%0b c=%0d sp=%0d",
                         i, bus.mpc, bus.waiting, bus.fault, bus.fault_cause, bus.sp,
                         vecs[i].e_mpc, vecs[i].e_w, vecs[i].e_f, vecs[i].e_c, vecs[i].e_sp);
            end
        end

        // Nested CALLs unwind in LIFO order.
        drive(0, 0, BR_SEQ, 0, 0, 16'h0, 0, 0);
        check("nest_reset_mpc", int'(bus.mpc), 0);
        drive(1, 0, BR_CALL, 10, 0, 16'h0, 0, 0);
        drive(1, 0, BR_CALL, 20, 0, 16'h0, 0, 0);
        drive(1, 0, BR_CALL, 30, 0, 16'h0, 0, 0);
        check("nest_call_mpc", int'(bus.mpc), 30);
        check("nest_call_sp", int'(bus.sp), 3);
        drive(1, 0, BR_RET, 0, 0, 16'h0, 0, 0);
        check("nest_ret1", int'(bus.mpc), 21);
        drive(1, 0, BR_RET, 0, 0, 16'h0, 0, 0);
        check("nest_ret2", int'(bus.mpc), 11);
        drive(1, 0, BR_RET, 0, 0, 16'h0, 0, 0);
        check("nest_ret3", int'(bus.mpc), 1);
        check("nest_sp_empty", int'(bus.sp), 0);

        // Long wait on a high condition select; waiting must persist every cycle.
        drive(1, 0, BR_WAIT, 0, 15, 16'h0000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            check("long_wait_flag", int'(bus.waiting), 1);
            check("long_wait_mpc", int'(bus.mpc), 1);
            drive(1, 0, BR_RET, 0, 3, 16'h7fff, 0, 0);
        end
        check("long_wait_held", int'(bus.waiting), 1);
        drive(1, 0, BR_RET, 0, 3, 16'h8000, 0, 0);
        check("long_wait_exit_mpc", int'(bus.mpc), 2);
        check("long_wait_exit_flag", int'(bus.waiting), 0);
        check("long_wait_no_fault", int'(bus.fault), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microprogram sequencer for the picoRISC control unit. Holds the micro-program counter (mPC) that addresses the asynchronous control ROM and computes the next mPC each cycle. Sources for the next mPC: sequential increment, branch field of the current microinstruction, condition-flag tests, opcode dispatch from the instruction decoder, or a micro-subroutine return stack. Sits between the decoder (dispatch address source) and the control ROM, and enforces stall and wait handshakes with the datapath and memory.

## Interface
- AW, 8: mPC / control ROM address width
- NC, 16: number of condition inputs (cond_sel width = clog2(NC))
- SD, 4: micro return stack depth
- FAULT_ADDR, 8'd255: mPC value held while in FAULT
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- br_type  in  3  branch type of current microinstruction (encoding below)
- br_target  in  AW  branch/call target field
- cond_sel  in  clog2(NC)  selects bit of cond
- cond  in  NC  datapath/memory status flags (e.g. memory done, Z, N, interrupt pending)
- disp_addr  in  AW  dispatch address from opcode decoder
- disp_valid  in  1  decoder matched an opcode (disp_addr meaningful)
- stall  in  1  freeze sequencer this cycle
- mpc  out  AW  current micro address, registered
- waiting  out  1  high while in WAITING state
- fault  out  1  high while in FAULT state
- fault_cause  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 dispatch miss
- sp  out  clog2(SD)+1  stack occupancy 0..SD

## Operation
- br_type: 0 SEQ mPC+1; 1 JMP br_target; 2 BRC br_target if cond[cond_sel] else mPC+1; 3 BRNC br_target if !cond[cond_sel] else mPC+1; 4 DISP disp_addr; 5 CALL push mPC+1, go br_target; 6 RET pop, go popped value; 7 WAIT go mPC+1 if cond[cond_sel], else enter WAITING.
- FSM states: RUN, WAITING, FAULT.
- RUN: evaluate br_type each unstalled cycle.
- WAITING: cond_sel is latched on entry. Fields are not re-sampled. mPC holds. When cond[latched sel] = 1: mPC <- mPC+1, return to RUN.
- FAULT: mPC = FAULT_ADDR, no further transitions. Exit only via reset.
- Fault conditions:
  - CALL with sp = SD -> FAULT, cause 01, no push.
  - RET with sp = 0 -> FAULT, cause 10.
  - DISP with disp_valid = 0 -> FAULT, cause 11.
- Increment is modulo 2^AW: mPC 255 + 1 = 0.
- Stall priority: stall = 1 blocks all updates (mPC, state, stack, latched cond_sel) in every state. Reset has priority over stall.
- CALL stores mPC+1 after wrap, so CALL at 255 pushes 0.

## Timing
- Reset state: mpc = 0, state RUN, sp = 0, waiting = 0, fault = 0, fault_cause = 00; stack contents don't-care.
- Control ROM is read asynchronously at mpc, so microinstruction fields are valid in the same cycle. Next mPC is combinational and registered on the edge: one microinstruction per unstalled cycle.
- Branch/dispatch latency: the target appears on mpc one cycle after the microinstruction is presented.
- WAIT exit: cond sampled high at edge N -> mpc = old+1 after edge N; waiting drops the same edge.
- Push and pop take effect on the same edge as the mPC update. A RET immediately after a CALL returns the value just pushed.
- Reset mid-WAITING or mid-FAULT: next edge with rst_n = 0 forces reset values.

## Structure
- Package micro_seq_pkg holds:
  - br_type encodings (BR_SEQ..BR_WAIT)
  - fault_cause codes
  - FSM state encoding
- Sub-module micro_ret_stack: SD x AW LIFO with push, pop, full, empty and sp outputs. It does no fault handling; the sequencer gates push/pop.

## Test plan
- Reset then SEQ from mpc 0 for 3 cycles -> mpc 1, 2, 3. At mpc 255 with SEQ -> mpc 0.
- BRC, cond_sel = 2:
  - cond[2] = 1, br_target = 40 -> mpc 40.
  - cond[2] = 0 -> mpc+1.
  - BRNC mirrored.
- DISP with disp_addr = 25, disp_valid = 1 -> mpc 25. Then DISP with disp_valid = 0 -> mpc 255, fault = 1, cause 11; stays there until rst_n low for one edge -> mpc 0.
- CALL at mpc 10 to 43, then RET -> mpc 43 then 11.
  - Five nested CALLs with SD = 4 -> fifth gives FAULT cause 01, sp = 4.
  - RET at sp = 0 -> cause 10.
- WAIT at mpc 22, cond_sel = 0, cond[0] low 3 cycles then high; cond_sel field changed during the wait -> waiting high 3 cycles, mpc 22 held, then mpc 23, with the latched select honored.
- stall = 1 for 2 cycles during CALL -> no push, mpc unchanged. Stall released -> push and jump occur once.
